uart_frame_parser: RTL and testbench

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's per-byte data/done pulse and hunts for a sync byte. It captures a length-prefixed payload into a local buffer and checks an XOR checksum. Only verified payload bytes are released, with a valid/ready handshake, to the decoder input logic; corrupt, truncated or overrun frames are discarded and flagged.

---
 rtl/uart_frame_parser.sv | 203 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Framing stage behind the UART receiver: hunts for SYNC, buffers a length-prefixed
// payload, verifies the XOR checksum and releases verified bytes over valid/ready.
module uart_frame_parser #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 32,
    parameter int         TIMEOUT = 229152
) (
    input  logic       clk_s,
    input  logic       rstn_s,
    input  logic [7:0] iDATA,
    input  logic       iDONE,
    output logic [7:0] oDATA,
    output logic       oVALID,
    input  logic       iREADY,
    output logic       oSOF,
    output logic       oEOF,
    output logic       oERR,
    output logic [2:0] oERR_CODE,
    output logic       oBUSY
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_ONE     = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PW-1:0] r_len;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_xor;
    logic [TW-1:0] r_tmo;
    logic          r_valid;
    logic          r_sof;
    logic          r_eof;
    logic          r_err;
    logic [2:0]    r_err_code;
    logic [7:0]    r_buf [MAX_LEN];
    logic [7:0]    r_rd_data;

    logic          w_xfer;
    logic          w_last_rd;
    logic          w_len_ok;
    logic          w_tmo_hit;
    logic          w_err;
    logic [2:0]    w_err_code;
    logic          w_load;
    logic          w_adv;
    logic          w_count;
    logic [AW-1:0] w_rd_addr;

    assign w_xfer    = r_valid & iREADY;
    assign w_last_rd = (r_rd_ptr == r_len - P_ONE);
    assign w_len_ok  = (iDATA != 8'h00) && (iDATA <= MAX_LEN_B);
    // An iDONE in the terminal count cycle wins over the timeout.
    assign w_tmo_hit = (r_tmo == TMO_LAST) && !iDONE;

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_err_code   = 3'd0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iDONE && iDATA == SYNC) w_state_next = S_LEN;
            end
            S_LEN: begin
                if (iDONE) begin
                    if (w_len_ok) begin
                        w_state_next = S_PAYLOAD;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = 3'd1;
                        w_state_next = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err        = 1'b1;
                    w_err_code   = 3'd3;
                    w_state_next = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (iDONE) begin
                    if (r_wr_ptr == r_len - P_ONE) w_state_next = S_CHK;
                end else if (w_tmo_hit) begin
                    w_err        = 1'b1;
                    w_err_code   = 3'd3;
                    w_state_next = S_IDLE;
                end
            end
            S_CHK: begin
                if (iDONE) begin
                    if (iDATA == r_xor) begin
                        w_load       = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_err        = 1'b1;
                        w_err_code   = 3'd2;
                        w_state_next = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err        = 1'b1;
                    w_err_code   = 3'd3;
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Bytes arriving mid-drain are dropped unexamined.
                if (iDONE) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd4;
                end
                if (w_xfer && w_last_rd) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_adv   = (r_state == S_DRAIN) && w_xfer && !w_last_rd;
    assign w_count = (r_state == S_LEN || r_state == S_PAYLOAD || r_state == S_CHK)
                     && (w_state_next != S_IDLE) && !iDONE;

    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            r_len      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_xor      <= 8'h00;
            r_tmo      <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            r_tmo <= w_count ? r_tmo + TW'(1) : '0;
            r_err <= w_err;
            if (w_err) r_err_code <= w_err_code;

            if (r_state == S_LEN && iDONE && w_len_ok) begin
                r_len    <= iDATA[PW-1:0];
                r_xor    <= iDATA;
                r_wr_ptr <= '0;
            end
            if (r_state == S_PAYLOAD && iDONE) begin
                r_wr_ptr <= r_wr_ptr + P_ONE;
                r_xor    <= r_xor ^ iDATA;
            end

            if (w_load) begin
                r_rd_ptr <= '0;
                r_valid  <= 1'b1;
                r_sof    <= 1'b1;
                r_eof    <= (r_len == P_ONE);
            end else if (w_adv) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
                r_sof    <= 1'b0;
                r_eof    <= (r_rd_ptr + P_ONE == r_len - P_ONE);
            end else if (r_state == S_DRAIN && w_xfer) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
            end
        end
    end

    // Read port fetches the byte to be presented next; it only moves on load or transfer.
    assign w_rd_addr = w_load ? '0 : (r_rd_ptr[AW-1:0] + AW'(1));

    always_ff @(posedge clk_s) begin
        if (r_state == S_PAYLOAD && iDONE) r_buf[r_wr_ptr[AW-1:0]] <= iDATA;
        if (w_load || w_adv) r_rd_data <= r_buf[w_rd_addr];
    end

    assign oDATA     = r_valid ? r_rd_data : 8'h00;
    assign oVALID    = r_valid;
    assign oSOF      = r_sof;
    assign oEOF      = r_eof;
    assign oERR      = r_err;
    assign oERR_CODE = r_err_code;
    assign oBUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: frames driven on iDATA/iDONE, outputs logged
// by a monitor and compared against hand-computed expectations.
module tb_uart_frame_parser;

    localparam int TMO = 40;

    logic       clk_s = 1'b0;
    logic       rstn_s;
    logic [7:0] iDATA;
    logic       iDONE;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       iREADY;
    logic       oSOF;
    logic       oEOF;
    logic       oERR;
    logic [2:0] oERR_CODE;
    logic       oBUSY;

    uart_frame_parser #(.SYNC(8'hA5), .MAX_LEN(32), .TIMEOUT(TMO)) dut (
        .clk_s     (clk_s),
        .rstn_s    (rstn_s),
        .iDATA     (iDATA),
        .iDONE     (iDONE),
        .oDATA     (oDATA),
        .oVALID    (oVALID),
        .iREADY    (iREADY),
        .oSOF      (oSOF),
        .oEOF      (oEOF),
        .oERR      (oERR),
        .oERR_CODE (oERR_CODE),
        .oBUSY     (oBUSY)
    );

    always #5 clk_s = ~clk_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_cyc;

    logic [9:0] xq[$];   // transfers: {sof, eof, data}
    int         xc[$];   // cycle of each transfer
    logic [9:0] sq[$];   // stalled presentations
    logic [2:0] eq[$];   // error codes seen
    int         err_cyc;
    int         zero_bad;

    always @(posedge clk_s) cyc <= cyc + 1;

    always @(negedge clk_s) begin
        #2;
        if (oVALID && iREADY) begin
            xq.push_back({oSOF, oEOF, oDATA});
            xc.push_back(cyc);
        end
        if (oVALID && !iREADY) sq.push_back({oSOF, oEOF, oDATA});
        if (!oVALID && oDATA != 8'h00) zero_bad++;
        if (oERR) begin
            eq.push_back(oERR_CODE);
            err_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk_s);
        iDATA    = b;
        iDONE    = 1'b1;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_s);
            iDONE = 1'b0;
            iDATA = 8'h00;
        end
    endtask

    task automatic clr();
        xq.delete();
        xc.delete();
        sq.delete();
        eq.delete();
        zero_bad = 0;
    endtask

    initial begin
        int t0;
        rstn_s = 1'b0;
        iDATA  = 8'h00;
        iDONE  = 1'b0;
        iREADY = 1'b1;
        zero_bad = 0;
        repeat (3) @(negedge clk_s);
        #1;
        check_val("rst_outputs", {oDATA, oVALID, oSOF, oEOF, oERR, oERR_CODE, oBUSY}, 32'h0);
        @(negedge clk_s);
        rstn_s = 1'b1;
        idle(2);

        // Good frame, back-to-back bytes: CHK = 03^11^22^33 = 03
        clr();
        put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h03);
        t0 = last_cyc;
        idle(8);
        check_val("good_count", xq.size(), 3);
        check_val("good_b0", xq[0], {2'b10, 8'h11});
        check_val("good_b1", xq[1], {2'b00, 8'h22});
        check_val("good_b2", xq[2], {2'b01, 8'h33});
        check_val("good_latency", xc[0] - t0, 1);
        check_val("good_no_bubble", xc[2] - xc[0], 2);
        check_val("good_no_err", eq.size(), 0);
        check_val("good_idle", oBUSY, 1'b0);

        // Bad checksum
        clr();
        put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h04);
        idle(5);
        check_val("badchk_errs", eq.size(), 1);
        check_val("badchk_code", eq[0], 3'd2);
        check_val("badchk_novalid", xq.size() + sq.size(), 0);
        check_val("badchk_idle", oBUSY, 1'b0);

        // Junk, zero length, then oversize length 0x21
        clr();
        put(8'h00); put(8'h7F); put(8'hA5); put(8'h00); put(8'hA5); put(8'h21);
        idle(4);
        check_val("badlen_errs", eq.size(), 2);
        check_val("badlen_code0", eq[0], 3'd1);
        check_val("badlen_code1", eq[1], 3'd1);
        check_val("badlen_idle", oBUSY, 1'b0);

        // Timeout: terminal count reached TMO cycles after the 44 byte, pulse one cycle later
        clr();
        put(8'hA5); put(8'h02); put(8'h44);
        t0 = last_cyc;
        for (int i = 0; i < 4 * TMO && eq.size() == 0; i++) idle(1);
        check_val("tmo_errs", eq.size(), 1);
        check_val("tmo_code", eq[0], 3'd3);
        check_val("tmo_delay", err_cyc - t0, TMO + 1);
        check_val("tmo_idle", oBUSY, 1'b0);

        // LEN byte lands exactly on the terminal count cycle: no timeout. CHK = 02^10^20 = 32
        clr();
        put(8'hA5);
        idle(TMO - 1);
        put(8'h02); put(8'h10); put(8'h20); put(8'h32);
        idle(6);
        check_val("edge_no_err", eq.size(), 0);
        check_val("edge_count", xq.size(), 2);
        check_val("edge_b0", xq[0], {2'b10, 8'h10});
        check_val("edge_b1", xq[1], {2'b01, 8'h20});

        // Backpressure + overrun. CHK = 02^5A^C3 = 9B
        clr();
        iREADY = 1'b0;
        put(8'hA5); put(8'h02); put(8'h5A); put(8'hC3); put(8'h9B);
        idle(2);
        put(8'hA5);               // injected during DRAIN, must not start a frame
        idle(3);
        iREADY = 1'b1;
        idle(6);
        check_val("bp_stall_cycles", sq.size(), 5);
        for (int i = 0; i < 5; i++) check_val($sformatf("bp_stall%0d", i), sq[i], {2'b10, 8'h5A});
        check_val("bp_count", xq.size(), 2);
        check_val("bp_b0", xq[0], {2'b10, 8'h5A});
        check_val("bp_b1", xq[1], {2'b01, 8'hC3});
        check_val("ovr_errs", eq.size(), 1);
        check_val("ovr_code", eq[0], 3'd4);
        check_val("ovr_idle", oBUSY, 1'b0);

        // Reset mid-frame
        clr();
        put(8'hA5); put(8'h04); put(8'h01); put(8'h02);
        @(negedge clk_s);
        iDONE = 1'b0;
        #1;
        check_val("midrst_busy_before", oBUSY, 1'b1);
        rstn_s = 1'b0;
        #1;
        check_val("midrst_outputs", {oDATA, oVALID, oSOF, oEOF, oERR, oERR_CODE, oBUSY}, 32'h0);
        idle(2);
        rstn_s = 1'b1;
        idle(2);
        put(8'hA5); put(8'h01); put(8'h7E); put(8'h7F);
        idle(5);
        check_val("midrst_no_err", eq.size(), 0);
        check_val("single_count", xq.size(), 1);
        check_val("single_b0", xq[0], {2'b11, 8'h7E});

        check_val("data_zero_when_idle", zero_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
